// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//
// Programmable serial sequence detector with a saturating hit counter and a
// registered 7-segment display of the count.
//
// A PAT_LEN-bit pattern register is loaded serially. The first bit shifted in
// ends up as the MSB, which is the oldest bit of a match. In detect mode each
// accepted bit (x_valid=1) is shifted into a history register. A match is
// flagged once PAT_LEN bits have been collected and the last PAT_LEN bits
// equal the pattern. Overlapping or non-overlapping detection is selected per
// accepted bit by the overlap input.
//
// Parameters
//   PAT_LEN   : pattern length in bits (2..8)
//   RESET_PAT : pattern loaded by reset
//   CNT_W     : hit counter width (1..8)
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   x         : serial data bit
//   x_valid   : x is accepted only when this is 1
//   load      : 1 = shift accepted bits into the pattern, 0 = detect
//   overlap   : 1 = overlapping detection, 0 = non-overlapping
//   clear     : synchronous clear of the hit counter (wins over increment)
//   match     : registered one-cycle detection pulse
//   hit_count : saturating number of matches
//   seg       : 7-segment drive {a,b,c,d,e,f,g,dp}, active-high
// -----------------------------------------------------------------------------
module seq_detect_prog #(
   parameter int unsigned        PAT_LEN   = 3,
   parameter logic [PAT_LEN-1:0] RESET_PAT = 3'b011,
   parameter int unsigned        CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             load,
   input  logic             overlap,
   input  logic             clear,
   output logic             match,
   output logic [CNT_W-1:0] hit_count,
   output logic [7:0]       seg
);

   // fill counts 0..PAT_LEN inclusive
   localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [6:0]         SEG_DASH  = 7'b0000001;
   localparam logic [7:0]         SEG_RESET = {SEG_DASH, 1'b0};

   // Hex digit to segments {a,b,c,d,e,f,g}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   logic [PAT_LEN-1:0] pat_q, pat_d;
   // Only PAT_LEN-1 history bits are stored; the oldest bit of a candidate
   // match is the one about to be shifted out, so it never needs a register.
   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   hit_q, hit_d;
   logic [7:0]         seg_q, seg_d;

   logic [PAT_LEN-1:0] hist_shift;
   logic [FILL_W-1:0]  fill_inc;
   logic [3:0]         hit_nib;

   always_comb begin
      pat_d      = pat_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      match_d    = 1'b0;
      hit_d      = hit_q;
      hist_shift = {hist_q, x};
      fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

      if (load) begin
         // Programming mode: detection is idle and restarts from scratch.
         hist_d = '0;
         fill_d = '0;
         if (x_valid) begin
            pat_d = {pat_q[PAT_LEN-2:0], x};
         end
      end else if (x_valid) begin
         hist_d = hist_shift[PAT_LEN-2:0];
         fill_d = fill_inc;
         if ((fill_inc == FILL_FULL) && (hist_shift == pat_q)) begin
            match_d = 1'b1;
            // Non-overlapping: the matched bits may not be reused.
            if (!overlap) begin
               fill_d = '0;
            end
         end
      end

      if (clear) begin
         hit_d = '0;
      end else if (match_d && (hit_q != CNT_MAX)) begin
         hit_d = hit_q + CNT_W'(1);
      end

      // Display the low hex digit of the next count; zero shows a dash.
      hit_nib = 4'(hit_d);
      if (hit_d == '0) begin
         seg_d = {SEG_DASH, match_d};
      end else begin
         seg_d = {hex_to_seg(hit_nib), match_d};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= RESET_PAT;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         hit_q   <= '0;
         seg_q   <= SEG_RESET;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         hit_q   <= hit_d;
         seg_q   <= seg_d;
      end
   end

   assign match     = match_q;
   assign hit_count = hit_q;
   assign seg       = seg_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_prog
//
// Directed bench for seq_detect_prog with default parameters. Each step drives
// one cycle of inputs, pushes the expected registered outputs to a queue, and
// pops/compares them just after the clock edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_prog;

   logic       clk;
   logic       reset;
   logic       x;
   logic       x_valid;
   logic       load;
   logic       overlap;
   logic       clear;
   logic       match;
   logic [3:0] hit_count;
   logic [7:0] seg;

   typedef struct {
      string      tag;
      logic       m;
      logic [3:0] c;
      logic [7:0] s;
   } exp_t;

   exp_t       sb_q[$];
   int         n_asserts = 0;
   int         n_fail    = 0;
   logic [3:0] exp_cnt   = 4'd0;

   seq_detect_prog dut (
      .clk       (clk),
      .reset     (reset),
      .x         (x),
      .x_valid   (x_valid),
      .load      (load),
      .overlap   (overlap),
      .clear     (clear),
      .match     (match),
      .hit_count (hit_count),
      .seg       (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Segments {a,b,c,d,e,f,g}; zero count is a dash.
   function automatic logic [6:0] digit_seg(input logic [3:0] c);
      logic [6:0] tbl [16];
      tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
      if (c == 4'd0) return 7'b0000001;
      return tbl[c];
   endfunction

   task automatic push_exp(input string tag, input logic em);
      exp_t e;
      e.tag = tag;
      e.m   = em;
      e.c   = exp_cnt;
      e.s   = {digit_seg(exp_cnt), em};
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_asserts++;
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 entries expected>=1");
         return;
      end
      e = sb_q.pop_front();
      n_asserts++;
      assert (match === e.m) else begin
         n_fail++;
         $error("FAIL %s.match observed=%b expected=%b", e.tag, match, e.m);
      end
      n_asserts++;
      assert (hit_count === e.c) else begin
         n_fail++;
         $error("FAIL %s.hit_count observed=%0d expected=%0d", e.tag, hit_count, e.c);
      end
      n_asserts++;
      assert (seg === e.s) else begin
         n_fail++;
         $error("FAIL %s.seg observed=%b expected=%b", e.tag, seg, e.s);
      end
   endtask

   // One clock of stimulus; em is the match expected on the following cycle.
   task automatic step(input logic xi, input logic vi, input logic li, input logic oi,
                       input logic ci, input logic em, input string tag);
      x       = xi;
      x_valid = vi;
      load    = li;
      overlap = oi;
      clear   = ci;
      if (ci) exp_cnt = 4'd0;
      else if (em && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      push_exp(tag, em);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic load_pat(input logic b2, input logic b1, input logic b0);
      step(b2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "load");
      step(b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "load");
      step(b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "load");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      x       = 1'b0;
      x_valid = 1'b0;
      load    = 1'b0;
      overlap = 1'b0;
      clear   = 1'b0;
      #3;
      push_exp("reset", 1'b0);
      check_out();
      #4;
      reset = 1'b0;

      // Default pattern 011, non-overlapping
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "def_b0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "def_b1");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "def_hit");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "def_after");

      // Pattern 101, overlapping: two matches in 1,0,1,0,1
      load_pat(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "clr0");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "ov_1");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "ov_2");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "ov_3");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "ov_4");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "ov_5");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ov_idle");

      // Same stream, non-overlapping: one match
      load_pat(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr1");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "nov_1");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "nov_2");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "nov_3");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "nov_4");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "nov_5");

      // Build count to 3, then clear on a match edge
      load_pat(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "c3_1");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "c3_2");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "c3_3");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "c3_4");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "c3_5");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "c3_6");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "clr_on_hit");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr_after");

      // 17 overlapping matches: counter saturates at 15
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sat_0");
         step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "sat_1");
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_idle");

      // Mid-stream async reset discards history
      load_pat(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_b0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_b1");
      #2;
      reset = 1'b1;
      #1;
      exp_cnt = 4'd0;
      push_exp("async_rst", 1'b0);
      check_out();
      #1;
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_1");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_2");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_3");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst_hit");

      // Invalid cycles with x toggling are ignored
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "v_0");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "inv_a");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "inv_b");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "v_1");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "inv_c");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "inv_d");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "v_hit");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "v_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 3, giving the pattern length in bits (legal range 2..8).
REQ-002 The block SHALL have parameter RESET_PAT, default 3'b011, PAT_LEN bits wide, giving the pattern loaded at reset.
REQ-003 The block SHALL have parameter CNT_W, default 4, giving the match-counter width (legal range 1..8).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port x, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port x_valid, input, 1 bit: x is sampled only on edges where x_valid=1.
REQ-008 The block SHALL have port load, input, 1 bit: 1 = shift accepted bits into the pattern register; 0 = detect.
REQ-009 The block SHALL have port overlap, input, 1 bit: 1 = overlapping detection; 0 = non-overlapping.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear of the hit counter.
REQ-011 The block SHALL have port match, output, 1 bit: registered one-cycle detection pulse.
REQ-012 The block SHALL have port hit_count, output, CNT_W bits: saturating count of matches.
REQ-013 The block SHALL have port seg, output, 8 bits: 7-segment drive, active-high, bit order {a,b,c,d,e,f,g,dp} = seg[7:0] (a=top, b=upper-right, c=lower-right, d=bottom, e=lower-left, f=upper-left, g=middle).

Function
REQ-014 When load=1 and x_valid=1, the block SHALL update pat <= {pat[PAT_LEN-2:0], x} (first bit shifted in ends up as the MSB, i.e. the oldest bit to be matched).
REQ-015 While load=1, the block SHALL hold history and fill at 0 and SHALL keep match at 0.
REQ-016 When load=0 and x_valid=1, the block SHALL update hist <= {hist[PAT_LEN-2:0], x} and SHALL increment fill, saturating at PAT_LEN.
REQ-017 When load=0 and x_valid=0, the block SHALL hold hist and fill unchanged.
REQ-018 On the edge where an accepted bit makes next-fill = PAT_LEN and next-hist = pat, the block SHALL set match to 1; match SHALL be high for exactly the following cycle (latency of 1 clock from the completing bit).
REQ-019 On a match with overlap=1, fill SHALL remain at PAT_LEN, so every subsequent bit may complete a new match.
REQ-020 On a match with overlap=0, fill SHALL be set to 0, so the next match requires PAT_LEN fresh accepted bits.
REQ-021 A change of overlap SHALL take effect on the next accepted bit; no other state SHALL change on the mode change.
REQ-022 On each match edge, hit_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-023 When clear=1, hit_count SHALL become 0 on the next edge, taking priority over a simultaneous increment; the match pulse itself SHALL still occur.
REQ-024 clear SHALL NOT affect pat, hist, fill or match.
REQ-025 seg SHALL be registered and update on the same edge as hit_count and match.
REQ-026 When the next hit_count = 0, seg[7:1] SHALL be 7'b0000001 (dash).
REQ-027 Otherwise, seg[7:1] SHALL show the hex digit of the next hit_count[3:0] (zero-extended if CNT_W<4) in standard segment shapes (e.g. 1 = b,c; 2 = a,b,d,e,g; 8 = all; F = a,e,f,g).
REQ-028 seg[0] (dp) SHALL equal the next match value.
REQ-029 The pattern register SHALL change only under load or reset.

Reset
REQ-030 While reset=1, asynchronously: pat=RESET_PAT, hist=0, fill=0, match=0, hit_count=0, seg=8'b00000010.
REQ-031 Reset asserted mid-stream SHALL discard partial history; a full PAT_LEN accepted bits SHALL be required after release before any match.
REQ-032 The first clk edge after reset release SHALL be a normal operating edge.

Verification
REQ-033 Defaults, overlap=0, stream 0,1,1 with x_valid=1 -> match=1 in the cycle after the 3rd bit with seg=8'b01100001, then match=0, hit_count=1, seg=8'b01100000.
REQ-034 Load 1,0,1 (load=1), then stream 1,0,1,0,1: with overlap=1 -> 2 matches, hit_count=2, seg=8'b11011010; with overlap=0 -> 1 match, hit_count=1.
REQ-035 CNT_W=4, 17 matches -> hit_count saturates at 15, seg=8'b10001110.
REQ-036 clear=1 on the edge of a match, hit_count previously 3 -> hit_count=0, seg=8'b00000011 for one cycle, then seg=8'b00000010.
REQ-037 Stream 0,1, then async reset pulse between edges, then stream 1 -> outputs return to reset values immediately and no match occurs; then stream 0,1,1 -> 1 match.
REQ-038 Stream 0,1,1 with x_valid=0 cycles (x toggling) interleaved -> exactly 1 match, occurring 1 cycle after the 3rd valid bit.
